acc_seq_ctrl: RTL and testbench

Sequencing controller plus accumulator datapath for the accumulator unit. Accepts a Start command carrying an operand count N, then drives the operand-select mux: load path for the first operand, adder-feedback path for the rest. It consumes exactly N operands over a valid/ready stream, and reports the wrapped sum with a sticky overflow flag and a one-cycle Done pulse. Sits between the command source and the 2:1 select mux / accumulator register, and owns the mux OP select.

---
 rtl/acc_pkg.sv | 17 +
 rtl/acc_mux.sv | 18 +
 rtl/acc_seq_ctrl.sv | 113 +++++++++++
 tb/tb_acc_seq_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator sequencing unit.
package acc_pkg;

  localparam int unsigned W_DEF  = 8;
  localparam int unsigned CW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } accState_t;

  localparam logic OP_LOAD     = 1'b0;
  localparam logic OP_FEEDBACK = 1'b1;

endpackage

// File: rtl/acc_mux.sv
// W-bit 2:1 operand-select mux: OP_LOAD picks A, OP_FEEDBACK picks B.
module acc_mux
  import acc_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         OP,
  output logic [W-1:0] Out
);

  // Select between the load operand and the adder feedback value.
  always_comb begin
    Out = (OP == OP_FEEDBACK) ? B : A;
  end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Accumulator sequencing controller: takes a Start/Count command, consumes
// exactly Count operands over a valid/ready stream and reports the wrapped
// sum, a sticky overflow flag and a one-cycle Done pulse.
module acc_seq_ctrl
  import acc_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          Start,
  input  logic [CW-1:0] Count,
  input  logic [W-1:0]  In_Data,
  input  logic          In_Valid,
  output logic          In_Ready,
  output logic          OP,
  output logic [W-1:0]  Result,
  output logic          Overflow,
  output logic          Busy,
  output logic          Done
);

  accState_t     state;
  accState_t     nextState;
  logic [CW-1:0] remaining;
  logic          accept;
  logic [W:0]    sumFull;
  logic [W-1:0]  muxOut;

  // W+1-bit add so the carry-out feeds the sticky overflow flag.
  always_comb begin
    sumFull = {1'b0, Result} + {1'b0, In_Data};
  end

  acc_mux #(.W(W)) uMux (
    .A   (In_Data),
    .B   (sumFull[W-1:0]),
    .OP  (OP),
    .Out (muxOut)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and state-decoded outputs; outputs depend on state only,
  // accept/nextState are the only terms that look at In_Valid/Start.
  always_comb begin
    nextState = state;
    In_Ready  = 1'b0;
    OP        = OP_LOAD;
    Busy      = 1'b0;
    Done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          nextState = (Count == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        In_Ready = 1'b1;
        Busy     = 1'b1;
        accept   = In_Valid;
        if (In_Valid) begin
          nextState = (remaining == CW'(1)) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        In_Ready = 1'b1;
        Busy     = 1'b1;
        OP       = OP_FEEDBACK;
        accept   = In_Valid;
        if (In_Valid && (remaining == CW'(1))) begin
          nextState = DONE;
        end
      end
      DONE: begin
        Done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Count and accumulator registers; all hold while no operand is accepted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Result    <= '0;
      Overflow  <= 1'b0;
      remaining <= '0;
    end else if ((state == IDLE) && Start) begin
      remaining <= Count;
      Overflow  <= 1'b0;
      if (Count == '0) begin
        Result <= '0;
      end
    end else if (accept) begin
      Result    <= muxOut;
      remaining <= remaining - CW'(1);
      if (state == ACCUM) begin
        Overflow <= Overflow | sumFull[W];
      end
    end
  end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Scoreboard bench for acc_seq_ctrl: directed jobs push expected results,
// a monitor pops and compares on every Done pulse.
module tb_acc_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       Start;
  logic [3:0] Count;
  logic [7:0] In_Data;
  logic       In_Valid;
  logic       In_Ready;
  logic       OP;
  logic [7:0] Result;
  logic       Overflow;
  logic       Busy;
  logic       Done;

  typedef struct packed {
    logic [7:0] res;
    logic       ovf;
  } exp_t;

  exp_t sbQ[$];
  int   tests = 0;
  int   fails = 0;

  acc_seq_ctrl #(.W(8), .CW(4)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .Start    (Start),
    .Count    (Count),
    .In_Data  (In_Data),
    .In_Valid (In_Valid),
    .In_Ready (In_Ready),
    .OP       (OP),
    .Result   (Result),
    .Overflow (Overflow),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && Done === 1'b1) begin
      if (sbQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL doneUnexpected: got Done=1 with Result=%0d expected no Done", Result);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        check("result", {24'd0, Result}, {24'd0, e.res});
        check("overflow", {31'd0, Overflow}, {31'd0, e.ovf});
      end
    end
  end

  task automatic checkIdleOutputs(input string tag);
    check({tag, ".result"},   {24'd0, Result}, 32'd0);
    check({tag, ".overflow"}, {31'd0, Overflow}, 32'd0);
    check({tag, ".inReady"},  {31'd0, In_Ready}, 32'd0);
    check({tag, ".op"},       {31'd0, OP}, 32'd0);
    check({tag, ".busy"},     {31'd0, Busy}, 32'd0);
    check({tag, ".done"},     {31'd0, Done}, 32'd0);
  endtask

  // Called #1 after a rising edge with the DUT in IDLE.
  task automatic startJob(input logic [3:0] c);
    Start = 1'b1;
    Count = c;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    Count = ~c;
  endtask

  // Present one operand and hold it until accepted (bounded wait).
  task automatic feed(input logic [7:0] d, input logic expOp);
    int n = 0;
    In_Valid = 1'b1;
    In_Data  = d;
    while (In_Ready !== 1'b1 && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (In_Ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL feedTimeout: got In_Ready=%0b expected 1 within 20 cycles", In_Ready);
    end else begin
      check("opSelect", {31'd0, OP}, {31'd0, expOp});
    end
    @(posedge CLK);
    #1;
    In_Valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL globalTimeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    RST_N = 1'b0; Start = 1'b0; Count = '0; In_Data = '0; In_Valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkIdleOutputs("inReset");
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    checkIdleOutputs("afterReset");

    // Basic sum 5+7+9 at full rate; Done right after the third accept edge.
    sbQ.push_back('{res: 8'd21, ovf: 1'b0});
    startJob(4'd3);
    check("basic.busy", {31'd0, Busy}, 32'd1);
    check("basic.inReady", {31'd0, In_Ready}, 32'd1);
    feed(8'd5, 1'b0);
    feed(8'd7, 1'b1);
    feed(8'd9, 1'b1);
    check("basic.doneTiming", {31'd0, Done}, 32'd1);
    check("basic.busyInDone", {31'd0, Busy}, 32'd0);
    @(posedge CLK); #1;
    check("basic.donePulseWidth", {31'd0, Done}, 32'd0);
    check("basic.resultHeld", {24'd0, Result}, 32'd21);

    // Wrap: 200+100 = 300 -> 44 with carry.
    sbQ.push_back('{res: 8'd44, ovf: 1'b1});
    startJob(4'd2);
    feed(8'd200, 1'b0);
    feed(8'd100, 1'b1);
    check("wrap.done", {31'd0, Done}, 32'd1);
    @(posedge CLK); #1;
    check("wrap.overflowHeld", {31'd0, Overflow}, 32'd1);

    // Single operand clears the sticky flag.
    sbQ.push_back('{res: 8'd3, ovf: 1'b0});
    startJob(4'd1);
    feed(8'd3, 1'b0);
    check("single.done", {31'd0, Done}, 32'd1);
    @(posedge CLK); #1;

    // Stall with a Start pulse that must be ignored.
    sbQ.push_back('{res: 8'd30, ovf: 1'b0});
    startJob(4'd2);
    feed(8'd10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("stall.busy", {31'd0, Busy}, 32'd1);
      check("stall.result", {24'd0, Result}, 32'd10);
      if (i == 1) begin
        Start = 1'b1;
        Count = 4'd5;
      end
      @(posedge CLK); #1;
      Start = 1'b0;
    end
    feed(8'd20, 1'b1);
    check("stall.done", {31'd0, Done}, 32'd1);
    @(posedge CLK); #1;
    check("stall.ignoredStartBusy", {31'd0, Busy}, 32'd0);
    check("stall.ignoredStartInReady", {31'd0, In_Ready}, 32'd0);

    // Count = 0: immediate Done, Result cleared, never ready.
    sbQ.push_back('{res: 8'd0, ovf: 1'b0});
    startJob(4'd0);
    check("zero.done", {31'd0, Done}, 32'd1);
    check("zero.inReady", {31'd0, In_Ready}, 32'd0);
    @(posedge CLK); #1;
    check("zero.inReadyAfter", {31'd0, In_Ready}, 32'd0);
    check("zero.doneAfter", {31'd0, Done}, 32'd0);

    // Reset mid-job after two accepts with overflow already set.
    startJob(4'd4);
    feed(8'd200, 1'b0);
    feed(8'd100, 1'b1);
    check("midJob.overflowSet", {31'd0, Overflow}, 32'd1);
    RST_N = 1'b0;
    #1;
    checkIdleOutputs("midJobReset");
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    checkIdleOutputs("midJobRelease");
    sbQ.push_back('{res: 8'd9, ovf: 1'b0});
    startJob(4'd1);
    feed(8'd9, 1'b0);
    check("fresh.done", {31'd0, Done}, 32'd1);

    repeat (3) @(posedge CLK);
    #1;
    check("scoreboardDrained", sbQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
